// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apu_pkg
//  Description : Constants and types shared by the UART register bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package apu_pkg;

  localparam int MSG_ADDR_FLAG  = 7;
  localparam int MSG_RSVD       = 6;
  localparam int DEFAULT_CLK_HZ = 12_000_000;
  localparam int DEFAULT_BAUD   = 9_600;
  localparam int APU_ADDR_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with 2-FF synchronizer and mid-bit sampling.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import apu_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT   = CLK_HZ / BAUD;
  localparam int HALF  = BIT / 2;
  localparam int CNT_W = $clog2(BIT);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic            r_rx_meta;
  logic            r_rx_sync;
  logic            r_rx_prev;
  rx_state_t       r_state;
  rx_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_frame_err;
  logic            w_fall;
  logic            w_half_hit;
  logic            w_bit_hit;
  logic            w_stop_bad;

  // Third stage only serves edge detection; the FSM samples r_rx_sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall     = r_rx_prev & ~r_rx_sync;
  assign w_half_hit = (r_cnt == c_half_last);
  assign w_bit_hit  = (r_cnt == c_bit_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_next = START;
      START:   if (w_half_hit) w_state_next = r_rx_sync ? IDLE : DATA;
      DATA:    if (w_bit_hit && (r_bit == 3'd7)) w_state_next = STOP;
      STOP:    if (w_bit_hit) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    w_stop_bad = 1'b0;
    if (r_state == STOP && w_bit_hit) begin
      byte_valid = r_rx_sync;
      w_stop_bad = ~r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_bit <= 3'd0;
        end
        START: r_cnt <= w_half_hit ? '0 : r_cnt + c_cnt_one;
        DATA: begin
          if (w_bit_hit) begin
            r_cnt   <= '0;
            r_bit   <= r_bit + 3'd1;
            r_shift <= {r_rx_sync, r_shift[7:1]};
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        STOP:    r_cnt <= w_bit_hit ? '0 : r_cnt + c_cnt_one;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign byte_data = r_shift;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_bridge
//  Description : Decodes UART data/address byte pairs into APU register writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_bridge
  import apu_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD,
  parameter int ADDR_W = APU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_data,
  output logic              frame_err,
  output logic              busy
);

  generate
    if (ADDR_W != APU_ADDR_W) begin : g_addr_w_check
      $error("uart_reg_bridge: ADDR_W must be 5");
    end
  endgenerate

  logic              w_byte_valid;
  logic [7:0]        w_byte;
  logic [6:0]        r_hold;
  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [7:0]        r_reg_data;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Hold survives writes so repeated address bytes reuse the last data value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= 7'h00;
      r_reg_wr   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= 8'h00;
    end else begin
      r_reg_wr <= 1'b0;
      if (w_byte_valid) begin
        if (!w_byte[MSG_ADDR_FLAG]) begin
          r_hold <= w_byte[6:0];
        end else if (!w_byte[MSG_RSVD]) begin
          r_reg_wr   <= 1'b1;
          r_reg_addr <= w_byte[ADDR_W:1];
          r_reg_data <= {w_byte[0], r_hold};
        end
      end
    end
  end

  assign reg_wr   = r_reg_wr;
  assign reg_addr = r_reg_addr;
  assign reg_data = r_reg_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_reg_bridge
//  Description : Directed self-checking bench for uart_reg_bridge (BIT = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

  localparam int TB_CLK_HZ = 160;
  localparam int TB_BAUD   = 10;
  localparam int BIT       = 16;
  localparam int HALF      = 8;
  // pin edge -> START is 3 edges, then HALF + 9 bit periods to the stop sample
  localparam int WR_LAT    = 3 + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       reg_wr;
  logic [4:0] reg_addr;
  logic [7:0] reg_data;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int t_fall = 0;
  int wr_count = 0;
  int ferr_count = 0;
  int wr_cycle = 0;
  int busy_run = 0;
  int busy_last_run = 0;
  logic [12:0] wr_q[$];

  uart_reg_bridge #(
    .CLK_HZ (TB_CLK_HZ),
    .BAUD   (TB_BAUD),
    .ADDR_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      wr_count = wr_count + 1;
      wr_cycle = cycle;
      wr_q.push_back({reg_addr, reg_data});
    end
    if (frame_err === 1'b1) ferr_count = ferr_count + 1;
    if (busy === 1'b1) busy_run = busy_run + 1;
    else if (busy_run != 0) begin
      busy_last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    t_fall = cycle;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rx = stop;
    repeat (BIT) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);
  endtask

  task automatic check_pair(input string name, input int idx, input logic [12:0] exp);
    n_cmp++;
    if (wr_q.size() <= idx || wr_q[idx] !== exp) begin
      n_bad++;
      $display("FAIL %s: got addr/data %h (writes seen %0d) want %h", name,
               (wr_q.size() > idx) ? wr_q[idx] : 13'h0, wr_q.size(), exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(4);
    n_cmp++;
    if ({reg_wr, reg_addr, reg_data, frame_err, busy} !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0000", {reg_wr, reg_addr, reg_data, frame_err, busy});
    end
    rst_n = 1'b1;
    wait_clks(4);
    n_cmp++;
    if ({reg_wr, reg_addr, reg_data, frame_err, busy} !== 16'h0000) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %h want 0000", {reg_wr, reg_addr, reg_data, frame_err, busy});
    end
  endtask

  task automatic test_basic_pair();
    int base_cnt = wr_count;
    int base_q = wr_q.size();
    send_byte(8'h3F, 1'b1);
    wait_clks(4);
    n_cmp++;
    if (wr_count - base_cnt !== 0) begin
      n_bad++;
      $display("FAIL basic_no_strobe_on_data: got %0d writes want 0", wr_count - base_cnt);
    end
    send_byte(8'h81, 1'b1);
    wait_clks(4);
    n_cmp++;
    if (wr_count - base_cnt !== 1) begin
      n_bad++;
      $display("FAIL basic_write_count: got %0d want 1", wr_count - base_cnt);
    end
    check_pair("basic_addr_data", base_q, {5'h00, 8'hBF});
    n_cmp++;
    if (wr_cycle - t_fall !== WR_LAT) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d want %0d", wr_cycle - t_fall, WR_LAT);
    end
  endtask

  task automatic test_back_to_back();
    int base_cnt = wr_count;
    int base_q = wr_q.size();
    send_byte(8'h0B, 1'b1);
    send_byte(8'h95, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h9D, 1'b1);
    send_byte(8'h3F, 1'b1);
    send_byte(8'h98, 1'b1);
    wait_clks(4);
    n_cmp++;
    if (wr_count - base_cnt !== 3) begin
      n_bad++;
      $display("FAIL b2b_write_count: got %0d want 3", wr_count - base_cnt);
    end
    check_pair("b2b_first", base_q, {5'h0A, 8'h8B});
    check_pair("b2b_second", base_q + 1, {5'h0E, 8'h85});
    check_pair("b2b_third", base_q + 2, {5'h0C, 8'h3F});
    wait_clks(30);
    n_cmp++;
    if ({reg_wr, reg_addr, reg_data} !== {1'b0, 5'h0C, 8'h3F}) begin
      n_bad++;
      $display("FAIL b2b_outputs_held: got %h want %h", {reg_wr, reg_addr, reg_data}, {1'b0, 5'h0C, 8'h3F});
    end
  endtask

  task automatic test_frame_err();
    int base_cnt;
    int base_q;
    int base_ferr;
    do_reset();
    base_cnt = wr_count;
    base_q = wr_q.size();
    base_ferr = ferr_count;
    send_byte(8'h12, 1'b0);
    wait_clks(4);
    n_cmp++;
    if (ferr_count - base_ferr !== 1) begin
      n_bad++;
      $display("FAIL ferr_pulse_cycles: got %0d want 1", ferr_count - base_ferr);
    end
    n_cmp++;
    if (wr_count - base_cnt !== 0) begin
      n_bad++;
      $display("FAIL ferr_no_write: got %0d want 0", wr_count - base_cnt);
    end
    send_byte(8'h84, 1'b1);
    wait_clks(4);
    check_pair("ferr_hold_untouched", base_q, {5'h02, 8'h00});
    n_cmp++;
    if (ferr_count - base_ferr !== 1) begin
      n_bad++;
      $display("FAIL ferr_good_frame_quiet: got %0d want 1", ferr_count - base_ferr);
    end
  endtask

  task automatic test_glitch();
    int base_cnt = wr_count;
    int base_q = wr_q.size();
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    wait_clks(20);
    n_cmp++;
    if (busy_last_run !== HALF || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy_width: got %0d busy=%b want %0d busy=0", busy_last_run, busy, HALF);
    end
    n_cmp++;
    if (wr_count - base_cnt !== 0) begin
      n_bad++;
      $display("FAIL glitch_no_write: got %0d want 0", wr_count - base_cnt);
    end
    send_byte(8'h17, 1'b1);
    send_byte(8'h84, 1'b1);
    wait_clks(4);
    check_pair("glitch_then_pair", base_q, {5'h02, 8'h17});
  endtask

  task automatic test_reserved();
    int base_cnt = wr_count;
    int base_q = wr_q.size();
    send_byte(8'h7F, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h83, 1'b1);
    wait_clks(4);
    n_cmp++;
    if (wr_count - base_cnt !== 1) begin
      n_bad++;
      $display("FAIL rsvd_write_count: got %0d want 1", wr_count - base_cnt);
    end
    check_pair("rsvd_addr_data", base_q, {5'h01, 8'hFF});
  endtask

  task automatic test_reset_midframe();
    logic [7:0] partial = 8'h55;
    int base_cnt;
    int base_q;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 rx = partial[i];
      repeat ((i == 4) ? HALF : BIT) @(posedge clk);
    end
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({reg_wr, reg_addr, reg_data, frame_err, busy} !== 16'h0000) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h want 0000", {reg_wr, reg_addr, reg_data, frame_err, busy});
    end
    rx = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(5);
    base_cnt = wr_count;
    base_q = wr_q.size();
    send_byte(8'h01, 1'b1);
    wait_clks(4);
    n_cmp++;
    if (wr_count - base_cnt !== 0) begin
      n_bad++;
      $display("FAIL midreset_no_early_write: got %0d want 0", wr_count - base_cnt);
    end
    send_byte(8'h86, 1'b1);
    wait_clks(4);
    check_pair("midreset_pair", base_q, {5'h03, 8'h01});
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reserved();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
